alu_share_arbiter: RTL and testbench

Shares one combinational 32-bit ALU between two requesters (e.g. the datapath and a self-test/debug engine).
- Round-robin arbitration with valid/ready handshakes on the request and response sides.
- Registers the operands sent to the ALU, then captures the ALU result and zero flag into a held response.
- Sits between the requesters and a single ALU instance, which is external to this block.

---
 rtl/alu_share_pkg.sv | 17 +
 rtl/alu_share_arbiter_rr_arb2.sv | 38 +++
 rtl/alu_share_arbiter.sv | 160 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM encoding,
// default widths and requester ids.
package alu_share_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int DATA_W_DEF = 32;
   localparam int OP_W_DEF   = 4;

   localparam logic REQ0_ID = 1'b0;
   localparam logic REQ1_ID = 1'b1;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone valid wins outright, and a tie goes to
// the requester named by the pointer.
module rr_arb2
   import alu_share_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       ptr,
   input  logic       en,
   output logic [1:0] grant,
   output logic       grant_id
);

   always_comb begin
      grant    = 2'b00;
      grant_id = REQ0_ID;
      if (en) begin
         unique case (valid)
            2'b01: begin
               grant    = 2'b01;
               grant_id = REQ0_ID;
            end
            2'b10: begin
               grant    = 2'b10;
               grant_id = REQ1_ID;
            end
            2'b11: begin
               grant    = ptr ? 2'b10 : 2'b01;
               grant_id = ptr;
            end
            default: begin
               grant    = 2'b00;
               grant_id = REQ0_ID;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters, with
// registered operands and a held response per requester.
//
// state | meaning
// IDLE  | arbitrate; a grant latches operands into alu_*
// EXEC  | ALU settles on the registered operands for one cycle
// RESP  | result held for the granted requester until rsp*_ready
module alu_share_arbiter
   import alu_share_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int OP_W   = OP_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OP_W-1:0]   req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_result,
   output logic              rsp0_zero,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_result,
   output logic              rsp1_zero,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   output logic              busy
);

   state_t            state_q, state_d;
   logic              ptr_q, ptr_d;
   logic              gid_q, gid_d;
   logic [OP_W-1:0]   alu_op_q, alu_op_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic              rsp0_valid_q, rsp0_valid_d;
   logic              rsp1_valid_q, rsp1_valid_d;
   logic [DATA_W-1:0] rsp0_result_q, rsp0_result_d;
   logic [DATA_W-1:0] rsp1_result_q, rsp1_result_d;
   logic              rsp0_zero_q, rsp0_zero_d;
   logic              rsp1_zero_q, rsp1_zero_d;
   logic [1:0]        grant;
   logic              grant_id;
   logic              rsp_done;

   rr_arb2 u_rr_arb2 (
      .valid    ({req1_valid, req0_valid}),
      .ptr      (ptr_q),
      .en       (state_q == ST_IDLE),
      .grant    (grant),
      .grant_id (grant_id)
   );

   // Ready is masked while reset is held so nothing looks accepted in reset.
   assign req0_ready = grant[0] & rst_n;
   assign req1_ready = grant[1] & rst_n;

   assign rsp_done = (gid_q == REQ1_ID) ? rsp1_ready : rsp0_ready;

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      gid_d         = gid_q;
      alu_op_d      = alu_op_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      rsp0_valid_d  = rsp0_valid_q;
      rsp1_valid_d  = rsp1_valid_q;
      rsp0_result_d = rsp0_result_q;
      rsp1_result_d = rsp1_result_q;
      rsp0_zero_d   = rsp0_zero_q;
      rsp1_zero_d   = rsp1_zero_q;
      unique case (state_q)
         ST_IDLE: begin
            if (grant != 2'b00) begin
               gid_d    = grant_id;
               alu_op_d = (grant_id == REQ1_ID) ? req1_op : req0_op;
               alu_a_d  = (grant_id == REQ1_ID) ? req1_a  : req0_a;
               alu_b_d  = (grant_id == REQ1_ID) ? req1_b  : req0_b;
               state_d  = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (gid_q == REQ1_ID) begin
               rsp1_valid_d  = 1'b1;
               rsp1_result_d = alu_result;
               rsp1_zero_d   = alu_zero;
            end else begin
               rsp0_valid_d  = 1'b1;
               rsp0_result_d = alu_result;
               rsp0_zero_d   = alu_zero;
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_done) begin
               rsp0_valid_d = 1'b0;
               rsp1_valid_d = 1'b0;
               ptr_d        = ~gid_q;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         ptr_q         <= 1'b0;
         gid_q         <= REQ0_ID;
         alu_op_q      <= '0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         rsp0_valid_q  <= 1'b0;
         rsp1_valid_q  <= 1'b0;
         rsp0_result_q <= '0;
         rsp1_result_q <= '0;
         rsp0_zero_q   <= 1'b0;
         rsp1_zero_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         gid_q         <= gid_d;
         alu_op_q      <= alu_op_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         rsp0_valid_q  <= rsp0_valid_d;
         rsp1_valid_q  <= rsp1_valid_d;
         rsp0_result_q <= rsp0_result_d;
         rsp1_result_q <= rsp1_result_d;
         rsp0_zero_q   <= rsp0_zero_d;
         rsp1_zero_q   <= rsp1_zero_d;
      end
   end

   assign alu_op      = alu_op_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign rsp0_valid  = rsp0_valid_q;
   assign rsp1_valid  = rsp1_valid_q;
   assign rsp0_result = rsp0_result_q;
   assign rsp1_result = rsp1_result_q;
   assign rsp0_zero   = rsp0_zero_q;
   assign rsp1_zero   = rsp1_zero_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small reference ALU
// (0=add, 1=sub, 2=and, 3=or, 4=xor) wired to the alu_* ports.
module tb_alu_share_arbiter;

   localparam int DW = 32;
   localparam int OW = 4;
   localparam logic [OW-1:0] OP_ADD = 4'd0;
   localparam logic [OW-1:0] OP_SUB = 4'd1;
   localparam logic [OW-1:0] OP_AND = 4'd2;
   localparam logic [OW-1:0] OP_OR  = 4'd3;
   localparam logic [OW-1:0] OP_XOR = 4'd4;

   logic          clk;
   logic          rst_n;
   logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
   logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
   logic [OW-1:0] req0_op, req1_op, alu_op;
   logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [DW-1:0] rsp0_result, rsp1_result;
   logic [DW-1:0] alu_a, alu_b, alu_result;
   logic          alu_zero, busy;

   int total = 0;
   int bad   = 0;

   alu_share_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_op     (req0_op),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .rsp0_valid  (rsp0_valid),
      .rsp0_ready  (rsp0_ready),
      .rsp0_result (rsp0_result),
      .rsp0_zero   (rsp0_zero),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_op     (req1_op),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .rsp1_valid  (rsp1_valid),
      .rsp1_ready  (rsp1_ready),
      .rsp1_result (rsp1_result),
      .rsp1_zero   (rsp1_zero),
      .alu_op      (alu_op),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_result  (alu_result),
      .alu_zero    (alu_zero),
      .busy        (busy)
   );

   always_comb begin
      alu_result = '0;
      case (alu_op)
         OP_ADD:  alu_result = alu_a + alu_b;
         OP_SUB:  alu_result = alu_a - alu_b;
         OP_AND:  alu_result = alu_a & alu_b;
         OP_OR:   alu_result = alu_a | alu_b;
         OP_XOR:  alu_result = alu_a ^ alu_b;
         default: alu_result = '0;
      endcase
   end
   assign alu_zero = (alu_result == '0);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run time limit expired");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic test_reset();
      #2;
      total++;
      if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero} !== 7'b0) begin
         bad++;
         $display("FAIL reset_flags: got %b expected 0", {busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero});
      end
      total++;
      if ({alu_op, alu_a, alu_b, rsp0_result, rsp1_result} !== '0) begin
         bad++;
         $display("FAIL reset_data: got %h expected 0", {alu_op, alu_a, alu_b, rsp0_result, rsp1_result});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'h5; req0_b = 32'h3; rsp0_ready = 1'b1;
      #1;
      total++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL single_grant: got r0=%b r1=%b busy=%b expected 1 0 0", req0_ready, req1_ready, busy);
      end
      @(posedge clk); #1 req0_valid = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || rsp0_valid !== 1'b0 || alu_a !== 32'h5 || alu_b !== 32'h3 || alu_op !== OP_ADD) begin
         bad++;
         $display("FAIL single_exec: got busy=%b v=%b a=%h b=%h op=%h", busy, rsp0_valid, alu_a, alu_b, alu_op);
      end
      @(negedge clk);
      total++;
      if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h8 || rsp0_zero !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL single_rsp: got v=%b res=%h z=%b busy=%b expected 1 8 0 1", rsp0_valid, rsp0_result, rsp0_zero, busy);
      end
      @(negedge clk);
      total++;
      if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL single_done: got v=%b busy=%b expected 0 0", rsp0_valid, busy);
      end
   endtask

   task automatic test_zero_flag();
      req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 32'h12345678; req1_b = 32'h12345678; rsp1_ready = 1'b1;
      #1 chk("zero_req1_ready", {31'b0, req1_ready}, 32'd1);
      @(posedge clk); #1 req1_valid = 1'b0;
      @(negedge clk) chk("zero_rsp0_quiet_exec", {31'b0, rsp0_valid}, 32'd0);
      @(negedge clk);
      chk("zero_rsp1_valid", {31'b0, rsp1_valid}, 32'd1);
      chk("zero_rsp1_result", rsp1_result, 32'h0);
      chk("zero_rsp1_zero", {31'b0, rsp1_zero}, 32'd1);
      chk("zero_rsp0_quiet_resp", {31'b0, rsp0_valid}, 32'd0);
      @(negedge clk) chk("zero_done", {30'b0, rsp1_valid, busy}, 32'd0);
   endtask

   task automatic test_contention();
      logic [DW-1:0] exp_a, exp_b, exp_r;
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd10;     req0_b = 32'd20;
      req1_valid = 1'b1; req1_op = OP_XOR; req1_a = 32'hFF00;   req1_b = 32'h0F0F;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_a = (k % 2 == 1) ? 32'hFF00 : 32'd10;
         exp_b = (k % 2 == 1) ? 32'h0F0F : 32'd20;
         exp_r = (k % 2 == 1) ? 32'hF00F : 32'd30;
         #1 chk($sformatf("cont_ready_%0d", k), {30'b0, req1_ready, req0_ready},
                (k % 2 == 1) ? 32'd2 : 32'd1);
         @(negedge clk);
         chk($sformatf("cont_alu_a_%0d", k), alu_a, exp_a);
         chk($sformatf("cont_alu_b_%0d", k), alu_b, exp_b);
         @(negedge clk);
         chk($sformatf("cont_rsp_valid_%0d", k), {30'b0, rsp1_valid, rsp0_valid},
             (k % 2 == 1) ? 32'd2 : 32'd1);
         chk($sformatf("cont_result_%0d", k), (k % 2 == 1) ? rsp1_result : rsp0_result, exp_r);
         @(negedge clk);
         chk($sformatf("cont_idle_%0d", k), {31'b0, busy}, 32'd0);
      end
   endtask

   task automatic test_stall();
      rsp0_ready = 1'b0;
      req0_op = OP_AND; req0_a = 32'hF0F0_1234; req0_b = 32'h0FF0_FF00;
      #1 chk("stall_grant0", {30'b0, req1_ready, req0_ready}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall_valid_%0d", i), {31'b0, rsp0_valid}, 32'd1);
         chk($sformatf("stall_result_%0d", i), rsp0_result, 32'h00F0_1200);
         chk($sformatf("stall_zero_%0d", i), {31'b0, rsp0_zero}, 32'd0);
         chk($sformatf("stall_req1_ready_%0d", i), {31'b0, req1_ready}, 32'd0);
         @(negedge clk);
      end
      rsp0_ready = 1'b1;
      #1 chk("stall_still_held", {30'b0, rsp0_valid, req1_ready}, 32'd2);
      @(negedge clk);
      chk("stall_released", {30'b0, rsp0_valid, busy}, 32'd0);
      chk("stall_next_grant", {30'b0, req1_ready, req0_ready}, 32'd2);
      @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk) chk("stall_alu_a_req1", alu_a, 32'hFF00);
      @(negedge clk) chk("stall_rsp1", rsp1_result, 32'hF00F);
      @(negedge clk) chk("stall_idle", {31'b0, busy}, 32'd0);
   endtask

   task automatic test_reset_midop();
      req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd1; req0_b = 32'd1; rsp0_ready = 1'b0;
      @(posedge clk); #3;
      chk("midop_in_exec", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midop_flags", {25'b0, busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero}, 32'd0);
      chk("midop_alu_a", alu_a, 32'd0);
      chk("midop_alu_op", {28'b0, alu_op}, 32'd0);
      @(negedge clk);
      req0_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_lone_requester();
      req1_valid = 1'b1; req1_op = OP_OR; req1_a = 32'hF0; req1_b = 32'h0F; rsp1_ready = 1'b1;
      #1 chk("lone_grant1", {30'b0, req1_ready, req0_ready}, 32'd2);
      @(posedge clk); #1 req1_valid = 1'b0;
      @(negedge clk) chk("lone_no_rsp0_exec", {31'b0, rsp0_valid}, 32'd0);
      @(negedge clk);
      chk("lone_rsp1_valid", {31'b0, rsp1_valid}, 32'd1);
      chk("lone_rsp1_result", rsp1_result, 32'hFF);
      chk("lone_no_rsp0_resp", {31'b0, rsp0_valid}, 32'd0);
      @(negedge clk) chk("lone_idle", {29'b0, busy, rsp0_valid, rsp1_valid}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0; rsp0_ready = 1'b0;
      req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; rsp1_ready = 1'b0;
      req0_valid = 1'b1;
      test_reset();
      req0_valid = 1'b0;
      test_single();
      test_zero_flag();
      test_contention();
      test_stall();
      test_reset_midop();
      test_lone_requester();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
